pipe_stage_skid: RTL and testbench

//  Parametrised, flushable pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
//  It replaces the fixed, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  It adds back-pressure, bubble insertion on flush, and a saturating stall-cycle counter.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_sat_cnt.sv | 34 +++
 rtl/pipe_stage_skid.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the flushable pipeline stage: FSM state encoding and width.
package pipe_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != {CNT_W{1'b1}})) begin
            value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Flushable valid/ready pipeline stage register with optional 2-entry skid buffer
// and a saturating stall-cycle counter. Bubbles always carry zero control.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              in_fire;
    logic              out_fire;
    logic              stall_inc;

    assign valid_o   = (state_q != ST_EMPTY);
    assign in_fire   = valid_i & ready_o;
    assign out_fire  = valid_o & ready_i;
    assign data_o    = main_data_q;
    assign ctrl_o    = main_ctrl_q;
    assign stall_inc = valid_o & ~ready_i;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        // Flush overrides every transfer; a beat accepted this cycle is dropped.
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_MAIN;
                        main_data_d = data_i;
                        main_ctrl_d = ctrl_i;
                    end
                end
                ST_MAIN: begin
                    if (in_fire && out_fire) begin
                        main_data_d = data_i;
                        main_ctrl_d = ctrl_i;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d     = ST_MAIN;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        // Data is left stale on a bubble; only control must read as zero.
        if (state_d == ST_EMPTY) begin
            main_ctrl_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_data_d;
            logic [CTRL_W-1:0] skid_ctrl_d;
            logic              skid_load;
            logic              ready_q;
            logic              ready_d;

            assign skid_load = ~flush_i & (state_q == ST_MAIN) & in_fire & ~out_fire;

            always_comb begin
                skid_data_d = skid_data_q;
                skid_ctrl_d = skid_ctrl_q;
                if (skid_load) begin
                    skid_data_d = data_i;
                    skid_ctrl_d = ctrl_i;
                end
                ready_d = (state_d != ST_FULL);
            end

            always_ff @(posedge clk_i or negedge start_i) begin
                if (!start_i) begin
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                    ready_q     <= 1'b0;
                end else begin
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                    ready_q     <= ready_d;
                end
            end

            assign ready_o = ready_q;
        end else begin : g_noskid
            // Single entry: accept only when the held beat leaves this cycle.
            assign skid_data_q = '0;
            assign skid_ctrl_q = '0;
            assign ready_o     = start_i & (~valid_o | ready_i);
        end
    endgenerate

    pipe_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_ni(start_i),
        .inc   (stall_inc),
        .clr   (cnt_clr_i),
        .value (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: one SKID=1 (CNT_W=4) and one SKID=0 instance
// share stimulus; each is checked against a FIFO-of-accepted-beats reference model.
module tb_pipe_stage_skid;

    localparam int DW    = 32;
    localparam int CW    = 8;
    localparam int DEPTH = 4096;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          flush   = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_i  = '0;
    logic [CW-1:0] ctrl_i  = '0;

    logic          rdy_o [2];
    logic          vld_o [2];
    logic [DW-1:0] dout  [2];
    logic [CW-1:0] cout  [2];
    logic [3:0]    stall0;
    logic [15:0]   stall1;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4), .SKID(1)) u_dut_skid (
        .clk_i(clk), .start_i(rst_n), .flush_i(flush), .cnt_clr_i(cnt_clr),
        .valid_i(valid_i), .ready_o(rdy_o[0]), .data_i(data_i), .ctrl_i(ctrl_i),
        .valid_o(vld_o[0]), .ready_i(ready_i), .data_o(dout[0]), .ctrl_o(cout[0]),
        .stall_cnt_o(stall0)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16), .SKID(0)) u_dut_noskid (
        .clk_i(clk), .start_i(rst_n), .flush_i(flush), .cnt_clr_i(cnt_clr),
        .valid_i(valid_i), .ready_o(rdy_o[1]), .data_i(data_i), .ctrl_i(ctrl_i),
        .valid_o(vld_o[1]), .ready_i(ready_i), .data_o(dout[1]), .ctrl_o(cout[1]),
        .stall_cnt_o(stall1)
    );

    // Reference model: accepted beats live in exp_* between head() and wr.
    logic [DW-1:0] exp_d [2][DEPTH];
    logic [CW-1:0] exp_c [2][DEPTH];
    int            wr      [2] = '{0, 0};
    int            rd      [2] = '{0, 0};
    int            kill    [2] = '{0, 0};
    int            stall_m [2] = '{0, 0};
    logic          rdy_m0      = 1'b0;

    int checks   = 0;
    int failures = 0;

    function automatic int head(input int k);
        return (rd[k] > kill[k]) ? rd[k] : kill[k];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic r);
        valid_i = v;
        data_i  = d;
        ctrl_i  = c;
        ready_i = r;
        cyc();
    endtask

    // Model update: runs after the monitor, before the next rising edge.
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (rst_n) #1;
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    kill[k]    = wr[k];
                    stall_m[k] = 0;
                end
                rdy_m0 = 1'b0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    int   h;
                    int   occ;
                    int   smax;
                    logic rdy;
                    h    = head(k);
                    occ  = wr[k] - h;
                    smax = (k == 0) ? 15 : 65535;
                    rdy  = (k == 0) ? rdy_m0 : (ready_i || (occ == 0));
                    if (cnt_clr) stall_m[k] = 0;
                    else if ((occ > 0) && !ready_i && (stall_m[k] < smax)) stall_m[k]++;
                    if (flush) begin
                        kill[k] = wr[k];
                    end else if (valid_i && rdy) begin
                        exp_d[k][wr[k] % DEPTH] = data_i;
                        exp_c[k][wr[k] % DEPTH] = ctrl_i;
                        wr[k]++;
                    end
                    if (k == 0) rdy_m0 = ((wr[0] - head(0)) < 2);
                end
            end
        end
    end

    // Monitor: compares what each DUT presents and retires delivered beats.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int   h;
                logic ev;
                logic er;
                h  = head(k);
                ev = ((wr[k] - h) > 0);
                er = (k == 0) ? rdy_m0 : (rst_n & (!ev | ready_i));
                chk($sformatf("dut%0d valid_o", k), 32'(vld_o[k]), 32'(ev));
                chk($sformatf("dut%0d ready_o", k), 32'(rdy_o[k]), 32'(er));
                chk($sformatf("dut%0d stall_cnt", k),
                    (k == 0) ? 32'(stall0) : 32'(stall1), 32'(stall_m[k]));
                if (!ev) begin
                    chk($sformatf("dut%0d bubble ctrl_o", k), 32'(cout[k]), 32'd0);
                end else begin
                    chk($sformatf("dut%0d data_o", k), dout[k], exp_d[k][h % DEPTH]);
                    chk($sformatf("dut%0d ctrl_o", k), 32'(cout[k]), 32'(exp_c[k][h % DEPTH]));
                    if (ready_i) rd[k] = h + 1;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s dut%0d valid_o", tag, k), 32'(vld_o[k]), 32'd0);
            chk($sformatf("%s dut%0d ready_o", tag, k), 32'(rdy_o[k]), 32'd0);
            chk($sformatf("%s dut%0d data_o", tag, k), dout[k], 32'd0);
            chk($sformatf("%s dut%0d ctrl_o", tag, k), 32'(cout[k]), 32'd0);
        end
        chk({tag, " stall0"}, 32'(stall0), 32'd0);
        chk({tag, " stall1"}, 32'(stall1), 32'd0);
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        cnt_clr = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        check_all_zero("reset");
        rst_n = 1'b1;
        chk("ready_o before first edge", 32'(rdy_o[0]), 32'd0);
        cyc();
        chk("ready_o after first edge", 32'(rdy_o[0]), 32'd1);

        // Full-rate stream
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), CW'(i + 16), 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        chk("stream stall0", 32'(stall0), 32'd0);
        chk("stream stall1", 32'(stall1), 32'd0);

        // Back-pressure for three cycles mid-stream
        clear_cnt();
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i + 32), CW'(i + 48), !(i inside {3, 4, 5}));
        repeat (3) drive(1'b0, '0, '0, 1'b1);
        chk("backpressure stall0", 32'(stall0), 32'd3);
        chk("backpressure stall1", 32'(stall1), 32'd3);

        // Drain from FULL (main=5, skid=6)
        clear_cnt();
        drive(1'b1, DW'(5), CW'(8'h55), 1'b0);
        drive(1'b1, DW'(6), CW'(8'h66), 1'b0);
        chk("full ready_o", 32'(rdy_o[0]), 32'd0);
        chk("full data_o", dout[0], 32'd5);
        drive(1'b0, '0, '0, 1'b1);
        chk("drain second data_o", dout[0], 32'd6);
        drive(1'b0, '0, '0, 1'b1);
        chk("drained valid_o", 32'(vld_o[0]), 32'd0);
        chk("drained ctrl_o", 32'(cout[0]), 32'd0);

        // Flush while FULL with a beat offered
        drive(1'b1, DW'(7), CW'(8'h77), 1'b0);
        drive(1'b1, DW'(8), CW'(8'h88), 1'b0);
        flush = 1'b1;
        drive(1'b1, DW'(9), CW'(8'h99), 1'b0);
        flush = 1'b0;
        chk("flush valid_o", 32'(vld_o[0]), 32'd0);
        chk("flush ctrl_o", 32'(cout[0]), 32'd0);
        chk("flush ready_o", 32'(rdy_o[0]), 32'd1);
        repeat (2) drive(1'b0, '0, '0, 1'b1);

        // Counter saturation and clear
        clear_cnt();
        drive(1'b1, DW'(10), CW'(8'hA0), 1'b0);
        repeat (20) drive(1'b0, '0, '0, 1'b0);
        chk("saturated stall0", 32'(stall0), 32'd15);
        chk("unsaturated stall1", 32'(stall1), 32'd20);
        cnt_clr = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        cnt_clr = 1'b0;
        chk("cleared stall0", 32'(stall0), 32'd0);
        chk("cleared stall1", 32'(stall1), 32'd0);
        repeat (2) drive(1'b0, '0, '0, 1'b1);

        // Asynchronous reset while FULL
        drive(1'b1, DW'(11), CW'(8'hB1), 1'b0);
        drive(1'b1, DW'(12), CW'(8'hC2), 1'b0);
        valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        repeat (2) cyc();
        rst_n = 1'b1;
        chk("post-reset ready_o before edge", 32'(rdy_o[0]), 32'd0);
        cyc();
        chk("post-reset ready_o after edge", 32'(rdy_o[0]), 32'd1);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            flush   = ($urandom_range(0, 31) == 0);
            cnt_clr = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 9) < 7, DW'($urandom), CW'($urandom_range(1, 255)),
                  $urandom_range(0, 9) < 6);
        end
        flush   = 1'b0;
        cnt_clr = 1'b0;
        repeat (6) drive(1'b0, '0, '0, 1'b1);
        chk("dut0 all beats delivered", 32'(wr[0] - head(0)), 32'd0);
        chk("dut1 all beats delivered", 32'(wr[1] - head(1)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
